decoder_rr_arbiter: RTL and testbench



---
 rtl/decoder_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Round-robin arbiter for four requesters that share one resource. The
// resource is selected through a 2-to-4 decoder. The arbiter registers the
// 2-bit index of the chosen requester and a grant-active flag. These two
// registers drive the decoder select and enable inputs. The one-hot grant is
// decoded from them with no further logic, so it changes only after a clock
// edge.
//
// Grant lifecycle:
//   IDLE  : When any request is present, the first requester found by
//           searching from ptr upward (wrapping 3 -> 0) receives the grant at
//           the next edge.
//   GRANT : The owner keeps the grant until one of the following happens,
//           checked in priority order:
//             1. it drops its request,
//             2. it pulses release_pulse,
//             3. it reaches MAX_HOLD cycles (timeout pulses for one cycle).
//           On exit the previous owner moves to lowest priority. Exactly one
//           dead cycle (grant == 0000) follows every grant.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles; 0 disables the timeout.
//             Legal range is 0 .. 2**CNT_W-1.
//   CNT_W     width of the hold counter.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   req[3:0]       request per requester (bit i = requester i)
//   release_pulse  single-cycle pulse from the current owner that ends its
//                  grant. `release` is a reserved word in SystemVerilog, so
//                  the port cannot use that name.
//   grant_idx[1:0] registered index of the current owner (decoder select)
//   grant_en       registered; high while a grant is active (decoder enable)
//   grant[3:0]     one-hot decode of grant_idx, gated by grant_en
//   timeout        registered one-cycle pulse when MAX_HOLD revokes a grant
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       release_pulse,
  output logic [1:0] grant_idx,
  output logic       grant_en,
  output logic [3:0] grant,
  output logic       timeout
);

  // A single state bit means grant_en can be taken straight from the state
  // flop. It is then a registered signal that needs no duplicate flop.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam bit HOLD_EN = (MAX_HOLD != 0);

  // hold_cnt is 0 during the first grant cycle. The grant is therefore
  // revoked in the cycle where hold_cnt reaches MAX_HOLD-1, which gives
  // exactly MAX_HOLD cycles of grant_en.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  // ---------------------------------------------------------------------------
  // Round-robin pick: returns the first set bit of r, searching start,
  // start+1, ... modulo 4. The 2-bit addition wraps naturally. The loop runs
  // from the farthest offset down to the nearest, so the nearest hit is
  // assigned last and wins. If r is zero the result is don't-care; the caller
  // only uses it when some request is present.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (r[cand]) idx = cand;
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic [1:0]       ptr_q,       ptr_d;
  logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic             timeout_q,   timeout_d;

  // Exit qualifiers. These are only meaningful while in ST_GRANT.
  logic owner_drop;
  logic owner_release;
  logic hold_hit;

  assign owner_drop    = ~req[grant_idx_q];
  assign owner_release = release_pulse;
  assign hold_hit      = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  // ---------------------------------------------------------------------------
  // Process 1: state register. Reset acts immediately, so grant collapses to
  // 0000 asynchronously.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= 2'd0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default before any branch; otherwise a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // release_pulse is deliberately ignored here. With no owner there is
        // no grant to end, and ptr must not move.
        if (req != 4'b0000) begin
          grant_idx_d = rr_pick(req, ptr_q);
          hold_cnt_d  = '0;
          state_d     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (owner_drop || owner_release || hold_hit) begin
          // Every exit path returns to IDLE and demotes the owner.
          // grant_idx keeps its value. Only grant_en drops, and that is
          // enough to blank the decoder.
          state_d = ST_IDLE;
          ptr_d   = grant_idx_q + 2'd1;
          // A normal exit in the same cycle masks the timeout.
          timeout_d = hold_hit && !owner_drop && !owner_release;
        end else if (hold_cnt_q != '1) begin
          // The counter saturates rather than wraps. This only matters when
          // the timeout is disabled and a grant runs indefinitely.
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs. Every output is a flop or a pure decode of flops.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_idx = grant_idx_q;
    grant_en  = (state_q == ST_GRANT);
    timeout   = timeout_q;
    grant     = grant_en ? (4'b0001 << grant_idx_q) : 4'b0000;
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Two arbiters share the same inputs. Instance A has MAX_HOLD=8; instance B
// has MAX_HOLD=0 (timeout disabled). The reference model tracks each
// instance as follows:
//   - the owner is an integer, with -1 meaning idle,
//   - the length of the current grant is a cycle count,
//   - the next grant comes from a modulo search from the rotating start
//     index.
// Every falling edge compares all outputs of both instances to the model.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;

  logic [1:0] idx_a, idx_b;
  logic       en_a,  en_b;
  logic [3:0] gnt_a, gnt_b;
  logic       to_a,  to_b;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  cmp_on   = 1'b0;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req), .release_pulse(rel),
    .grant_idx(idx_a), .grant_en(en_a), .grant(gnt_a), .timeout(to_a)
  );

  decoder_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req), .release_pulse(rel),
    .grant_idx(idx_b), .grant_en(en_b), .grant(gnt_b), .timeout(to_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model, one entry per instance
  // ---------------------------------------------------------------------------
  int m_owner [2];   // -1 = nobody holds the resource
  int m_idx   [2];   // last granted index (kept after the grant ends)
  int m_ptr   [2];   // where the next search starts
  int m_held  [2];   // cycles the current owner has held the grant so far
  bit m_to    [2];

  function automatic int max_hold_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit found;
    int c;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = -1; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
      end else begin
        m_to[k] = 0;
        if (m_owner[k] < 0) begin
          found = 0;
          for (int j = 0; j < 4; j++) begin
            c = (m_ptr[k] + j) % 4;
            if (!found && req[c]) begin
              found = 1; m_owner[k] = c; m_idx[k] = c; m_held[k] = 1;
            end
          end
        end else if (!req[m_owner[k]] || rel ||
                     (max_hold_of(k) != 0 && m_held[k] == max_hold_of(k))) begin
          m_to[k]    = req[m_owner[k]] && !rel;
          m_ptr[k]   = (m_owner[k] + 1) % 4;
          m_owner[k] = -1;
          m_held[k]  = 0;
        end else begin
          m_held[k]++;
        end
      end
    end
  end

  task automatic compare_one(input int k, input logic [1:0] idx, input logic en,
                             input logic [3:0] gnt, input logic to);
    logic [3:0] exp_g;
    exp_g = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
    check($sformatf("model_grant[%0d]", k),     32'(gnt), 32'(exp_g));
    check($sformatf("model_grant_en[%0d]", k),  32'(en),  32'(m_owner[k] >= 0));
    check($sformatf("model_grant_idx[%0d]", k), 32'(idx), 32'(m_idx[k]));
    check($sformatf("model_timeout[%0d]", k),   32'(to),  32'(m_to[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      compare_one(0, idx_a, en_a, gnt_a, to_a);
      compare_one(1, idx_b, en_b, gnt_b, to_b);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; rel = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    rst = 1'b1; req = 4'b0000; rel = 1'b0;
    tick(); tick();
    cmp_on = 1'b1;
    rst = 1'b0;

    // T1: asynchronous reset while 0100 is granted
    req = 4'b0100;
    tick();
    check("t1_granted", 32'(gnt_a), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("t1_async_grant",   32'(gnt_a), 32'h0);
    check("t1_async_en",      32'(en_a),  32'h0);
    check("t1_async_timeout", 32'(to_a),  32'h0);
    #3 rst = 1'b0;

    // T2: single requester, one-cycle latency, drop ends the grant
    do_reset();
    req = 4'b0001;
    tick();
    check("t2_grant", 32'(gnt_a), 32'h1);
    check("t2_idx",   32'(idx_a), 32'h0);
    req = 4'b0000;
    tick();
    check("t2_drop", 32'(gnt_a), 32'h0);

    // T3: all requesting; release two cycles into each grant
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_grant%0d", i), 32'(gnt_a), 32'(rr_seq[i]));
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check($sformatf("t3_dead%0d", i), 32'(gnt_a), 32'h0);
      tick();
    end

    // T4: timeout after exactly 8 grant cycles, then re-grant
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_hold%0d", i), 32'(gnt_a), 32'h4);
      check($sformatf("t4_no_to%0d", i), 32'(to_a), 32'h0);
      tick();
    end
    check("t4_dead_grant", 32'(gnt_a), 32'h0);
    check("t4_timeout",    32'(to_a),  32'h1);
    check("t4_b_no_to",    32'(to_b),  32'h0);
    check("t4_b_still",    32'(gnt_b), 32'h4);
    tick();
    check("t4_regrant", 32'(gnt_a), 32'h4);
    check("t4_to_clear", 32'(to_a), 32'h0);

    // T5a: release on the timeout cycle masks the timeout
    repeat (7) tick();
    check("t5_last_cycle", 32'(gnt_a), 32'h4);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    check("t5_masked_to", 32'(to_a),  32'h0);
    check("t5_dead",      32'(gnt_a), 32'h0);

    // T5b: after owner 1 exits, index 3 outranks index 1
    do_reset();
    req = 4'b0010;
    tick();
    check("t5_owner1", 32'(gnt_a), 32'h2);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = 4'b1010;
    tick();
    check("t5_next_grant", 32'(gnt_a), 32'h8);
    check("t5_next_idx",   32'(idx_a), 32'h3);

    // T6: release while idle is ignored
    do_reset();
    rel = 1'b1;
    tick();
    check("t6_idle_rel", 32'(gnt_a), 32'h0);
    rel = 1'b0;
    req = 4'b0010;
    tick();
    check("t6_grant", 32'(gnt_a), 32'h2);
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    tick();
    req = 4'b0000;
    tick();

    // Randomized phase: slowly changing requests, sparse releases, rare
    // mid-cycle resets. The negedge compare process checks every cycle.
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
      if ($urandom_range(0, 63) == 0) req = 4'($urandom);
      rel = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end

    rel = 1'b0;
    req = 4'b0000;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
